// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - Op encodings seen on the Op input
//   - FSM state encoding used by the controller
//   - default latencies for multiply and divide
//   - small decode helpers shared by the controller and md_calc
package mult_div_unit_pkg;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_NONE7 = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_calc.sv
// md_calc: purely combinational arithmetic for the multiply/divide unit.
// Ports:
//   a, b         : 32-bit operands (rs, rt)
//   op           : 3-bit op code
//   result       : {hi, lo} of the selected operation
//   div_by_zero  : high for div/divu with b == 0 (result then meaningless)
module md_calc
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] divisor_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;

    always_comb begin
        // The low 64 bits of a product of sign-extended operands equal the
        // signed 64-bit product, so no signed multiplier is needed.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};

        div_by_zero = is_div_op(op) && (b == 32'd0);

        // Divisor forced to 1 on zero so the dividers never see x/0.
        divisor_u = (b == 32'd0) ? 32'd1 : b;

        // Signed divide on magnitudes. |0x80000000| stays 0x80000000 as an
        // unsigned value, which makes 0x80000000 / -1 come out as 0x80000000.
        abs_a = a[31] ? (32'd0 - a) : a;
        abs_b = (b == 32'd0) ? 32'd1 : (b[31] ? (32'd0 - b) : b);
        q_mag = abs_a / abs_b;
        r_mag = abs_a % abs_b;
        q_s   = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
        r_s   = a[31] ? (32'd0 - r_mag) : r_mag;   // remainder takes dividend's sign

        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {r_s, q_s};
            OP_DIVU:  result = {a % divisor_u, a / divisor_u};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed at the start edge and held in pending registers;
// a down-counter models the architectural latency before HI/LO update.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset
//   A, B   : forwarded rs/rt operands from E
//   Op     : 000/111 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo
//   Busy   : operation in progress (stall source for the hazard unit)
//   HI, LO : architectural HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) > 4) ? $clog2(MAX_CYCLES) : 4;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;

    logic [63:0]      calc_result;
    logic             calc_div_by_zero;

    md_calc u_md_calc (
        .a           (A),
        .b           (B),
        .op          (Op),
        .result      (calc_result),
        .div_by_zero (calc_div_by_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;

        case (state_q)
            ST_IDLE: begin
                if (is_md_op(Op)) begin
                    // Operands are consumed here only; A/B changes later are irrelevant.
                    pend_hi_d = calc_result[63:32];
                    pend_lo_d = calc_result[31:0];
                    pend_dz_d = calc_div_by_zero;
                    cnt_d     = is_div_op(Op) ? DIV_LOAD : MULT_LOAD;
                    state_d   = ST_RUN;
                end else if (Op == OP_MTHI) begin
                    hi_d = A;
                end else if (Op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                // Op is deliberately not looked at while running.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, named as below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 A  input  32  forwarded rs operand from E stage.
REQ-007 B  input  32  forwarded rt operand from E stage.
REQ-008 Op  input  3  op code: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-009 Busy  output  1  operation in progress; the hazard unit stalls md/mfhi/mflo in D while high.
REQ-010 HI  output  32  HI register, registered.
REQ-011 LO  output  32  LO register, registered.

Function
REQ-012 States: IDLE, RUN; counter cnt (4 bits minimum) valid in RUN only.
REQ-013 IDLE with Op in {mult, multu, div, divu} sampled at edge k: capture result into pending regs, cnt loaded with N-1, go RUN, Busy=1 from edge k.
REQ-014 N = MULT_CYCLES for mult/multu and DIV_CYCLES for div/divu; Busy SHALL be high for exactly N cycles after edge k.
REQ-015 RUN: cnt decrements each edge; at the edge where cnt==0, HI/LO load pending values, Busy falls, state returns to IDLE.
REQ-016 HI/LO SHALL hold their old values throughout RUN; results become visible at edge k+N.
REQ-017 mult: {HI,LO} = signed A * signed B (64-bit); multu: unsigned product.
REQ-018 div: LO = A/B truncated toward zero, HI = remainder with dividend's sign; divu: unsigned quotient/remainder.
REQ-019 div with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 div/divu with B=0 SHALL still run DIV_CYCLES with Busy high and leave HI/LO unchanged at completion.
REQ-021 mthi/mtlo in IDLE SHALL write A into HI/LO at the same edge, with no Busy assertion.
REQ-022 Any Op sampled in RUN SHALL be ignored. The hazard unit guarantees none occurs; the block is still robust to one.
REQ-023 Op 000/111 in IDLE: no state change.
REQ-024 Operands SHALL be sampled only at the start edge; later changes on A/B have no effect.

Reset
REQ-025 reset==0 at an edge: HI=0, LO=0, Busy=0, state IDLE, cnt=0, pending regs=0, regardless of Op.
REQ-026 Reset during RUN SHALL abort the operation; the pending result is never committed.
REQ-027 Op SHALL be ignored on any edge where reset==0.

Structure
REQ-028 The shared package SHALL hold the Op encodings, the state encoding, and MULT_CYCLES/DIV_CYCLES defaults. The datapath and controller SHALL use the same package.
REQ-029 One combinational sub-module, md_calc, SHALL take (A, B, Op) and produce 64-bit {hi,lo} plus a div_by_zero flag. The FSM, counter and HI/LO registers SHALL stay in mult_div_unit.
REQ-030 The datapath instantiates this block in E and selects HI/LO toward E/M via its existing XALU select.

Verification
REQ-031 mult A=0xFFFFFFFE (-2), B=3 -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 div A=-7 (0xFFFFFFF9), B=2 -> Busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 with HI/LO preloaded to 0x11/0x22 -> unchanged after 10 cycles.
REQ-034 mthi A=0x1234 then mtlo A=0x5678 on consecutive edges -> HI=0x1234 and LO=0x5678 immediately; Busy never high.
REQ-035 div started, reset=0 at the 4th busy cycle -> next edge HI=LO=0, Busy=0; no late result write.
REQ-036 mult started, then Op=div held during RUN with changing A/B -> ignored; the mult result is committed at edge k+5 and Busy falls at the same edge.
